// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited memory requests, in-order response tracking,
// redirect flush and a DEPTH-entry prefetch FIFO. Optional FETCH_BYPASS_EN adds a 0-cycle bypass.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            Reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count, outstanding, drop;
    logic [PW-1:0]   wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] tag_mem  [DEPTH];
    logic [XLEN-1:0] tag_head;
    logic [CW:0]     credit_used;
    logic            accept, rsp_ok, rsp_live, bypass, push, pop;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: one idle cycle after reset, then run forever
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // outstanding counts every in-flight request, including those already marked for drop,
    // so count+outstanding bounds FIFO occupancy and drop can never exceed DEPTH.
    assign credit_used    = (CW + 1)'(count) + (CW + 1)'(outstanding);
    assign imem_req_valid = (state == RUN) && (credit_used < (CW + 1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
    assign rsp_live       = rsp_ok && (drop == '0) && !redirect_valid;
    assign tag_head       = tag_mem[tag_rd];

`ifdef FETCH_BYPASS_EN
    assign bypass      = rsp_live && (count == '0);
    assign instr_valid = (count != '0) || bypass;
    assign instr       = bypass ? imem_rsp_data : data_mem[rd_ptr];
    assign instr_pc    = bypass ? tag_head : pc_mem[rd_ptr];
`else
    assign bypass      = 1'b0;
    assign instr_valid = (count != '0);
    assign instr       = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
`endif

    assign push = rsp_live && !(bypass && instr_ready);
    assign pop  = (count != '0) && instr_ready && !redirect_valid;

    // Fetch PC and in-flight bookkeeping
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp_ok);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                drop     <= outstanding - CW'(rsp_ok);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_ok && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    // PC tag queue: one entry per live in-flight request, cleared on redirect
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag_mem[PW'(i)] <= '0;
        end else if (redirect_valid) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (accept) begin
                tag_mem[tag_wr] <= fetch_pc;
                tag_wr          <= tag_wr + PW'(1);
            end
            if (rsp_live) tag_rd <= tag_rd + PW'(1);
        end
    end

    // Prefetch FIFO of {instr, pc}
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[PW'(i)] <= '0;
                pc_mem[PW'(i)]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= imem_rsp_data;
                pc_mem[wr_ptr]   <= tag_head;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
